// File: rtl/mips_core_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcodes, functs,
// FSM states, ALU operation codes and instruction field extractors.
// Pure declarations; no timing or flow-control behaviour of its own.
package mips_core_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_IN    = 6'b011010;
  localparam logic [5:0] OP_OUT   = 6'b011011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (inst[5:0])
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ST_LOAD, ST_FETCH, ST_EXEC, ST_MEM, ST_WAIT_IN, ST_WAIT_OUT, ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_t;

  function automatic logic [5:0] f_op(input logic [31:0] inst);
    return inst[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] inst);
    return inst[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] inst);
    return inst[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] inst);
    return inst[15:11];
  endfunction

  function automatic logic [4:0] f_shamt(input logic [31:0] inst);
    return inst[10:6];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] inst);
    return inst[5:0];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] inst);
    return inst[15:0];
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU for the multi-cycle core: arithmetic, logic, SLT, shifts.
// Zero latency; purely combinational, no handshake.
// Shifts operate on b (the rt operand) by shamt, matching MIPS SLL/SRL.
module mips_alu
  import mips_core_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_t           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [4:0]        shamt_i,
  output logic [DATA_W-1:0] y_o
);

  // Select the operation result; all arithmetic wraps modulo 2^DATA_W
  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_NOR: y_o = ~(a_i | b_i);
      ALU_SLT: y_o = DATA_W'($signed(a_i) < $signed(b_i));
      ALU_SLL: y_o = b_i << shamt_i;
      ALU_SRL: y_o = b_i >> shamt_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_core_mc.sv
// Multi-cycle MIPS-subset core with LOAD mode (imem fill) and RUN mode.
// CPI 2 (FETCH/EXEC), LW 3 via MEM; IN/OUT stall in WAIT_IN/WAIT_OUT.
// IN waits for in_valid (in_ready pulses on consume); OUT holds out_valid until out_ready.
module mips_core_mc
  import mips_core_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NREG       = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_req,
  input  logic                          run_req,
  input  logic                          load_valid,
  input  logic [31:0]                   load_data,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  input  logic                          out_ready,
  output logic                          running,
  output logic                          trap,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc_dbg
);

  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);
  localparam int RIDX_W  = $clog2(NREG);

  // Architectural state
  state_t              state_q;
  logic [IMEM_AW-1:0]  pc_q;
  logic [IMEM_AW-1:0]  load_addr_q;
  logic [31:0]         ir_q;
  logic [DATA_W-1:0]   ld_data_q;
  logic [DATA_W-1:0]   rf_q [NREG];
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                trap_q;
  logic                running_q;

  logic [31:0]         imem [IMEM_DEPTH];
  logic [DATA_W-1:0]   dmem [DMEM_DEPTH];

  // Decoded fields of the instruction held in ir_q
  logic [5:0]          op_f;
  logic [5:0]          funct_f;
  logic [4:0]          shamt_f;
  logic [15:0]         imm_f;
  logic [RIDX_W-1:0]   rs_idx;
  logic [RIDX_W-1:0]   rt_idx;
  logic [RIDX_W-1:0]   rd_idx;
  logic [DATA_W-1:0]   rs_val;
  logic [DATA_W-1:0]   rt_val;
  logic [DATA_W-1:0]   imm_sx;
  logic [DATA_W-1:0]   lui_val;
  logic [IMEM_AW-1:0]  pc_inc;
  logic [IMEM_AW-1:0]  br_tgt;
  logic [IMEM_AW-1:0]  j_tgt;
  logic [DMEM_AW-1:0]  dm_addr;

  alu_op_t             alu_op;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_y;
  logic                illegal;
  logic                exec_go;
  logic                imem_we;
  logic                dmem_we;

  assign op_f    = f_op(ir_q);
  assign funct_f = f_funct(ir_q);
  assign shamt_f = f_shamt(ir_q);
  assign imm_f   = f_imm(ir_q);
  assign rs_idx  = RIDX_W'(f_rs(ir_q));
  assign rt_idx  = RIDX_W'(f_rt(ir_q));
  assign rd_idx  = RIDX_W'(f_rd(ir_q));

  // Register 0 is hardwired to zero on the read side; writes to it are dropped below
  assign rs_val  = (rs_idx == '0) ? '0 : rf_q[rs_idx];
  assign rt_val  = (rt_idx == '0) ? '0 : rf_q[rt_idx];

  assign imm_sx  = DATA_W'($signed(imm_f));
  assign lui_val = DATA_W'({imm_f, 16'h0000});
  assign pc_inc  = pc_q + IMEM_AW'(1);
  assign br_tgt  = pc_inc + IMEM_AW'($signed(imm_f));
  assign j_tgt   = IMEM_AW'(ir_q);
  assign dm_addr = DMEM_AW'(rs_val + imm_sx);

  // An in-flight instruction only commits when no reset or LOAD request overrides it
  assign exec_go = (state_q == ST_EXEC) && !rst && !load_req;
  assign imem_we = (state_q == ST_LOAD) && !rst && !load_req && !run_req && load_valid;
  assign dmem_we = exec_go && (op_f == OP_SW);

  assign in_ready  = (state_q == ST_WAIT_IN) && in_valid && !rst && !load_req;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign running   = running_q;
  assign trap      = trap_q;
  assign pc_dbg    = pc_q;

  mips_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i    (alu_op),
    .a_i     (rs_val),
    .b_i     (alu_b),
    .shamt_i (shamt_f),
    .y_o     (alu_y)
  );

  // Decode: pick the ALU operation and second operand, flag unknown opcode/funct
  always_comb begin
    illegal = 1'b0;
    alu_op  = ALU_ADD;
    alu_b   = imm_sx;
    case (op_f)
      OP_RTYPE: begin
        alu_b = rt_val;
        case (funct_f)
          FN_ADD, FN_JR: alu_op = ALU_ADD;
          FN_SUB:        alu_op = ALU_SUB;
          FN_AND:        alu_op = ALU_AND;
          FN_OR:         alu_op = ALU_OR;
          FN_NOR:        alu_op = ALU_NOR;
          FN_SLT:        alu_op = ALU_SLT;
          FN_SLL:        alu_op = ALU_SLL;
          FN_SRL:        alu_op = ALU_SRL;
          default:       illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LUI, OP_BEQ, OP_BNE, OP_J, OP_JAL,
      OP_LW, OP_SW, OP_IN, OP_OUT: illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

  // Instruction memory: filled word by word in LOAD, read into ir_q during FETCH
  always_ff @(posedge clk) begin
    if (imem_we) imem[load_addr_q] <= load_data;
    if (state_q == ST_FETCH) ir_q <= imem[pc_q];
  end

  // Data memory: SW writes in EXEC; the registered read captured in EXEC feeds LW in MEM
  always_ff @(posedge clk) begin
    if (dmem_we) dmem[dm_addr] <= rt_val;
    ld_data_q <= dmem[dm_addr];
  end

  // Control FSM with register-file writeback and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      pc_q        <= '0;
      load_addr_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      trap_q      <= 1'b0;
      running_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (load_req) begin
      state_q     <= ST_LOAD;
      load_addr_q <= '0;
      out_valid_q <= 1'b0;
      trap_q      <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD, ST_TRAP: begin
          if (run_req) begin
            pc_q      <= '0;
            state_q   <= ST_FETCH;
            running_q <= 1'b1;
            trap_q    <= 1'b0;
          end else if (state_q == ST_LOAD && load_valid) begin
            load_addr_q <= load_addr_q + IMEM_AW'(1);
          end
        end
        ST_FETCH: state_q <= ST_EXEC;
        ST_EXEC: begin
          state_q <= ST_FETCH;
          pc_q    <= pc_inc;
          if (illegal) begin
            // pc stays on the faulting instruction for debug
            state_q   <= ST_TRAP;
            pc_q      <= pc_q;
            trap_q    <= 1'b1;
            running_q <= 1'b0;
          end else begin
            case (op_f)
              OP_RTYPE: begin
                if (funct_f == FN_JR) pc_q <= IMEM_AW'(rs_val);
                else if (rd_idx != '0) rf_q[rd_idx] <= alu_y;
              end
              OP_ADDI: if (rt_idx != '0) rf_q[rt_idx] <= alu_y;
              OP_LUI:  if (rt_idx != '0) rf_q[rt_idx] <= lui_val;
              OP_BEQ:  if (rs_val == rt_val) pc_q <= br_tgt;
              OP_BNE:  if (rs_val != rt_val) pc_q <= br_tgt;
              OP_J:    pc_q <= j_tgt;
              OP_JAL: begin
                pc_q           <= j_tgt;
                rf_q[NREG-1]   <= DATA_W'(pc_inc);
              end
              OP_LW:   state_q <= ST_MEM;
              OP_IN: begin
                pc_q    <= pc_q;
                state_q <= ST_WAIT_IN;
              end
              OP_OUT: begin
                pc_q        <= pc_q;
                state_q     <= ST_WAIT_OUT;
                out_data_q  <= rs_val;
                out_valid_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_MEM: begin
          if (rt_idx != '0) rf_q[rt_idx] <= ld_data_q;
          state_q <= ST_FETCH;
        end
        ST_WAIT_IN: begin
          if (in_valid) begin
            if (rt_idx != '0) rf_q[rt_idx] <= in_data;
            pc_q    <= pc_inc;
            state_q <= ST_FETCH;
          end
        end
        ST_WAIT_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            pc_q        <= pc_inc;
            state_q     <= ST_FETCH;
          end
        end
        default: begin
          state_q   <= ST_LOAD;
          running_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mips_core_mc.md
Name: mips_core_mc

Overview:
Parametrised multi-cycle successor to the single-register-file LOAD/RUN core. It has a LOAD mode that fills instruction memory word by word and a RUN mode that executes a MIPS-subset program from address 0 through a FETCH/EXEC(/MEM) state machine. It adds on-chip data memory, branches and jumps, a trap on illegal opcodes, and valid/ready handshaked IN/OUT ports. It sits under the board top, behind the switch/LED glue.

Parameters:
DATA_W, 32, register/ALU/data-memory word width; minimum 16. Immediates are sign- or zero-extended to this width.
NREG, 32, number of registers (8, 16 or 32). Register index = low log2(NREG) bits of each 5-bit field.
IMEM_DEPTH, 256, instruction words (power of 2). PC width IMEM_AW = log2(IMEM_DEPTH).
DMEM_DEPTH, 256, data words (power of 2). Address = low log2(DMEM_DEPTH) bits of the effective address.

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
load_req  in  1  request LOAD mode (SW_N level)
run_req  in  1  request RUN mode (SW_S level)
load_valid  in  1  load_data is valid this cycle (LOAD mode only)
load_data  in  32  instruction word to store
in_valid  in  1  in_data is valid
in_data  in  DATA_W  input word
in_ready  out  1  one-cycle pulse when an IN instruction consumes in_data
out_valid  out  1  out_data is valid; held until out_ready
out_data  out  DATA_W  output word
out_ready  in  1  sink accepts out_data
running  out  1  state is not LOAD or TRAP (drives LED[7])
trap  out  1  illegal instruction seen
pc_dbg  out  IMEM_AW  current PC

Behaviour:
- Reset: state=LOAD, pc=0, load_addr=0, all registers=0, out_valid=0, out_data=0, in_ready=0, trap=0. Memory contents are not cleared.
- Mode priority each cycle: rst > load_req > run_req.
  - load_req in any state: state=LOAD, load_addr=0, out_valid=0, trap=0. Any in-flight instruction is abandoned with no writeback.
  - run_req in LOAD or TRAP: pc=0, state=FETCH.
  - run_req in any other state: ignored.
- LOAD: while load_valid=1, imem[load_addr]<=load_data and load_addr+1; wraps to 0 at IMEM_DEPTH.
- FETCH: synchronous imem read at pc; then EXEC.
- EXEC: decode and execute; default pc<=pc+1 (mod IMEM_DEPTH); back to FETCH. CPI is 2, LW is 3 via MEM, IN/OUT stall extra cycles.
- Register 0 always reads 0; writes to it are discarded.
- R-type, op 000000, selected by funct:
  - ADD 100000, SUB 100010, AND 100100, OR 100101, NOR 100111: rd<=rs op rt.
  - SLT 101010: rd<=(signed rs<rt).
  - SLL 000000, SRL 000010: rd<=rt shifted by shamt.
  - JR 001000: pc<=rs[IMEM_AW-1:0].
  - Any other funct: trap.
- I-type and J-type:
  - ADDI 001000: rt<=rs+sext(imm).
  - LUI 001111: rt<=imm<<16, truncated to DATA_W.
  - BEQ 000100 / BNE 000101: if taken, pc<=pc+1+sext(imm).
  - J 000010: pc<=inst[IMEM_AW-1:0].
  - JAL 000011: same as J, and r[NREG-1]<=pc+1.
  - LW 100011: address rs+sext(imm); go to MEM for the sync dmem read; rt<=data; then FETCH.
  - SW 101011: dmem[rs+sext(imm)]<=rt.
  - IN 011010: go to WAIT_IN.
  - OUT 011011: go to WAIT_OUT.
- WAIT_IN: hold until in_valid=1; then rt<=in_data, in_ready=1 for that cycle, pc+1, FETCH.
- WAIT_OUT: out_data<=rs and out_valid=1 on entry; hold until out_ready=1; then out_valid=0, pc+1, FETCH.
- Illegal opcode/funct: state=TRAP, trap=1, pc frozen at the faulting instruction. Leaves TRAP only via rst or load_req/run_req.
- Arithmetic wraps modulo 2^DATA_W with no overflow exception. Branch and jump targets wrap modulo IMEM_DEPTH. Executing past the last loaded word runs whatever imem holds.

Decomposition:
- Package mips_core_pkg:
  - opcode and funct localparams;
  - state enum {LOAD, FETCH, EXEC, MEM, WAIT_IN, WAIT_OUT, TRAP};
  - instruction field-extract functions.
- Sub-module mips_alu, combinational, parametrised by DATA_W: op select, a, b, shamt -> result.
- Memories, register file and FSM stay in mips_core_mc.

Test Plan:
- Load 0x20010005, 0x20020007, 0x00221820, 0x6C600000; pulse run_req -> out_valid with out_data=12 after FETCH/EXEC ×4 (8 cycles). Holding out_ready=0 keeps out_data=12 stable.
- Load 0x20010003, 0x2021FFFF, 0x1420FFFE, 0x6C200000; run -> ADDI executes 3 times; out_data=0; pc_dbg passes 1,2,1,2,1,2,3.
- Load 0x20011234, 0xAC010004, 0x8C020004, 0x6C400000; run -> out_data=0x1234; LW takes 3 cycles.
- Load 0x68050000, 0x6CA00000; hold in_valid=0 for 10 cycles -> pc_dbg stays 0, in_ready=0. Then in_valid=1 with in_data=0xA5 -> single in_ready pulse, out_data=0xA5.
- Load 0x20000009, 0xFC000000; run -> r0 still 0; trap=1, running=0, pc_dbg=1. Then load_req -> trap=0, state LOAD, load_addr=0.
- load_req and run_req high together from RUN -> LOAD wins, out_valid cleared. Assert rst mid-WAIT_OUT -> all outputs at reset values next cycle.
